vga_pixel_fetch: RTL and testbench
==================================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter IMG_W, default 320, meaning stored frame width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, meaning stored frame height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning frame-buffer word address width.
REQ-004 SHALL have parameter PIX_W, default 8, meaning grayscale edge-magnitude width.
REQ-005 SHALL have port vgaClk  input  1  pixel clock; sole clock, all logic on rising edge.
REQ-006 SHALL have port rstN  input  1  reset; synchronous, active-low.
REQ-007 SHALL have ports hCount, vCount  input  10 each  raster position from the VGA timing stage.
REQ-008 SHALL have ports hSyncIn, vSyncIn, blankBIn  input  1 each  active-low syncs and active-high display-enable from the timing stage.
REQ-009 SHALL have port frameDone  input  1  one-cycle pulse: edge engine finished writing the back buffer.
REQ-010 SHALL have ports rdEn output 1, rdBank output 1, rdAddr output ADDR_W  frame-buffer read request.
REQ-011 SHALL have port rdData  input  PIX_W  read data, valid exactly one cycle after rdEn.
REQ-012 SHALL have port wrBank  output  1  bank the edge engine writes (always ~rdBank).
REQ-013 SHALL have port swapAck  output  1  one-cycle pulse when banks swap.
REQ-014 SHALL have ports hSync, vSync, blankB  output  1 each  timing signals delayed to align with pixels.
REQ-015 SHALL have ports red, green, blue  output  8 each  pixel colour.

Function
REQ-016 SHALL compute x = hCount>>1, y = vCount>>1 (2x upscale of IMG_W x IMG_H to 640x480).
REQ-017 SHALL form address y*IMG_W + x using shift-add only (y<<8 + y<<6 + x for default), zero-extended to ADDR_W; max 76799.
REQ-018 SHALL assert rdEn at cycle N+1 iff at cycle N blankBIn=1, hCount<640 and vCount<480; rdAddr registered in same cycle.
REQ-019 SHALL hold rdAddr at its last value while rdEn=0.
REQ-020 SHALL delay hSyncIn, vSyncIn, blankBIn (and internal active flag) by exactly 3 cycles to hSync, vSync, blankB.
REQ-021 SHALL register red=green=blue=rdData (PIX_W>8: take MSBs; PIX_W<8: left-justify, zero-fill) at cycle N+3 when the delayed active flag is 1, else 0x00.
REQ-022 SHALL keep a display-bank register dispBank driving rdBank; wrBank = ~dispBank combinationally.
REQ-023 SHALL implement swap FSM with states IDLE and PENDING.
REQ-024 SHALL transition IDLE->PENDING on frameDone=1.
REQ-025 SHALL, in PENDING, at the swap point (hCount=0 and vCount=480), toggle dispBank, pulse swapAck for that one cycle, and go to IDLE.
REQ-026 SHALL treat frameDone in PENDING (not at swap point) as no-op; no queueing beyond one pending frame.
REQ-027 SHALL, when frameDone coincides with the swap point in PENDING, swap and remain in PENDING.
REQ-028 SHALL, when frameDone coincides with the swap point in IDLE, enter PENDING without swapping that frame.
REQ-029 SHALL never change rdBank except at the swap point, so no frame mixes banks.

Reset
REQ-030 SHALL, while rstN=0 at a clock edge, set: FSM=IDLE, dispBank=0, rdEn=0, rdAddr=0, swapAck=0, red/green/blue=0, blankB=0, hSync=1, vSync=1, all delay-pipe stages to those inactive values.
REQ-031 SHALL resume from reset on the first edge with rstN=1; first valid pixel appears 3 cycles after first active input.
REQ-032 SHALL, on reset asserted mid-frame or while PENDING, discard pending swap and return to dispBank=0.

Verification
REQ-033 SHALL cover: hCount=5,vCount=3,blankBIn=1 -> rdEn=1, rdAddr=1*320+2=322 one cycle later; rdData=0xA5 next cycle -> red=green=blue=0xA5 at N+3.
REQ-034 SHALL cover: hCount=639,vCount=479 -> rdAddr=76799; hCount=640 -> rdEn=0, rdAddr held 76799, RGB=0 at N+3.
REQ-035 SHALL cover: hSyncIn toggled at cycle N -> hSync toggles at exactly N+3; blankB tracks blankBIn with same delay.
REQ-036 SHALL cover: frameDone pulse at vCount=100 -> swapAck=1 and rdBank 0->1, wrBank 1->0 only at hCount=0,vCount=480; two frameDone pulses before swap -> single swap.
REQ-037 SHALL cover: frameDone at the swap point while PENDING -> swap occurs, second swap at next frame's swap point.
REQ-038 SHALL cover: rstN=0 for one cycle while PENDING with dispBank=1 -> dispBank=0, no swapAck at next swap point, all outputs at reset values.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
//   Turns the VGA raster position into frame-buffer reads and paints the
//   returned grayscale edge magnitude on R, G and B. The stored IMG_W x IMG_H
//   frame is shown 2x upscaled. The frame buffer has two banks. The edge
//   engine writes one bank while the other is displayed. The banks swap only
//   at the start of vertical blanking, so no displayed frame mixes banks.
//
// Ports
//   vgaClk                 pixel clock; all logic runs on its rising edge
//   rstN                   synchronous active-low reset
//   hCount, vCount         raster position from the timing stage
//   hSyncIn, vSyncIn       active-low syncs from the timing stage
//   blankBIn               active-high display enable from the timing stage
//   frameDone              one-cycle pulse: the back buffer is complete
//   rdEn, rdBank, rdAddr   frame-buffer read request (data returns 1 cycle later)
//   rdData                 frame-buffer read data
//   wrBank                 bank the edge engine may write (always ~rdBank)
//   swapAck                one-cycle pulse when the banks swap
//   hSync, vSync, blankB   timing signals delayed 3 cycles to line up with pixels
//   red, green, blue       pixel colour
module vga_pixel_fetch #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
) (
    input  logic              vgaClk,
    input  logic              rstN,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic              hSyncIn,
    input  logic              vSyncIn,
    input  logic              blankBIn,
    input  logic              frameDone,
    output logic              rdEn,
    output logic              rdBank,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [PIX_W-1:0]  rdData,
    output logic              wrBank,
    output logic              swapAck,
    output logic              hSync,
    output logic              vSync,
    output logic              blankB,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue
);

    localparam logic [0:0]  S_IDLE     = 1'b0;
    localparam logic [0:0]  S_PENDING  = 1'b1;
    localparam logic [15:0] IMG_W_BITS = 16'(IMG_W);
    localparam logic [9:0]  DISP_W     = 10'(2 * IMG_W);
    localparam logic [9:0]  DISP_H     = 10'(2 * IMG_H);

    // The top 8 bits of the pixel. Narrow pixels are left-justified and
    // zero-filled. Appending a zero byte keeps the slice legal for any PIX_W.
    function automatic logic [7:0] to_rgb8(input logic [PIX_W-1:0] d);
        logic [PIX_W+7:0] t;
        t = {d, 8'h00};
        return t[PIX_W+7 -: 8];
    endfunction

    logic [8:0]        w_x;
    logic [8:0]        w_y;
    logic [ADDR_W-1:0] w_addr;
    logic              w_active;
    logic              w_swapPt;

    logic [0:0]        r_state;
    logic              r_dispBank;
    logic              r_swapAck;
    logic              r_rdEn;
    logic [ADDR_W-1:0] r_rdAddr;
    logic              r_hs_p1, r_hs_p2, r_hs_p3;
    logic              r_vs_p1, r_vs_p2, r_vs_p3;
    logic              r_bl_p1, r_bl_p2, r_bl_p3;
    logic              r_act_p1, r_act_p2;
    logic [7:0]        r_pix_p3;

    assign w_x      = hCount[9:1];
    assign w_y      = vCount[9:1];
    assign w_active = blankBIn && (hCount < DISP_W) && (vCount < DISP_H);
    // The first blanked line begins here. Nothing is being displayed, so
    // this is the point where the bank may change.
    assign w_swapPt = (hCount == 10'd0) && (vCount == DISP_H);

    // y*IMG_W as a sum of shifted copies of y, one per set bit of IMG_W.
    // For 320 this is (y<<8) + (y<<6).
    always_comb begin
        w_addr = ADDR_W'(w_x);
        for (int k = 0; k < 16; k++) begin
            if (IMG_W_BITS[k]) begin
                w_addr = w_addr + (ADDR_W'(w_y) << k);
            end
        end
    end

    // Stage 1: issue the read; start the timing delay line
    always_ff @(posedge vgaClk) begin
        if (!rstN) begin
            r_rdEn   <= 1'b0;
            r_rdAddr <= '0;
            r_act_p1 <= 1'b0;
            r_hs_p1  <= 1'b1;
            r_vs_p1  <= 1'b1;
            r_bl_p1  <= 1'b0;
        end else begin
            r_rdEn   <= w_active;
            if (w_active) begin
                r_rdAddr <= w_addr;
            end
            r_act_p1 <= w_active;
            r_hs_p1  <= hSyncIn;
            r_vs_p1  <= vSyncIn;
            r_bl_p1  <= blankBIn;
        end
    end

    // Stage 2: wait while the frame buffer returns data
    always_ff @(posedge vgaClk) begin
        if (!rstN) begin
            r_act_p2 <= 1'b0;
            r_hs_p2  <= 1'b1;
            r_vs_p2  <= 1'b1;
            r_bl_p2  <= 1'b0;
        end else begin
            r_act_p2 <= r_act_p1;
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
            r_bl_p2  <= r_bl_p1;
        end
    end

    // Stage 3: capture the pixel; black outside the active area
    always_ff @(posedge vgaClk) begin
        if (!rstN) begin
            r_pix_p3 <= 8'h00;
            r_hs_p3  <= 1'b1;
            r_vs_p3  <= 1'b1;
            r_bl_p3  <= 1'b0;
        end else begin
            r_pix_p3 <= r_act_p2 ? to_rgb8(rdData) : 8'h00;
            r_hs_p3  <= r_hs_p2;
            r_vs_p3  <= r_vs_p2;
            r_bl_p3  <= r_bl_p2;
        end
    end

    // Bank swap control. At most one finished frame waits for the swap point.
    // A frameDone that arrives on the swap cycle itself refers to the newly
    // written back buffer, so it re-arms the pending state.
    always_ff @(posedge vgaClk) begin
        if (!rstN) begin
            r_state    <= S_IDLE;
            r_dispBank <= 1'b0;
            r_swapAck  <= 1'b0;
        end else begin
            r_swapAck <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frameDone) begin
                        r_state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (w_swapPt) begin
                        r_dispBank <= ~r_dispBank;
                        r_swapAck  <= 1'b1;
                        r_state    <= frameDone ? S_PENDING : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdEn    = r_rdEn;
    assign rdAddr  = r_rdAddr;
    assign rdBank  = r_dispBank;
    assign wrBank  = ~r_dispBank;
    assign swapAck = r_swapAck;
    assign hSync   = r_hs_p3;
    assign vSync   = r_vs_p3;
    assign blankB  = r_bl_p3;
    assign red     = r_pix_p3;
    assign green   = r_pix_p3;
    assign blue    = r_pix_p3;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Testbench for vga_pixel_fetch.
//   The bench drives the raster position directly, so any sequence of
//   positions can be applied, and answers read requests from a synthetic
//   two-bank frame buffer. A behavioural model predicts every output on
//   every cycle. It keeps the last three input samples, works out addresses
//   with plain arithmetic, and tracks the bank swap as a pending flag.
module tb_vga_pixel_fetch;

    logic        vgaClk = 1'b0;
    logic        rstN;
    logic [9:0]  hCount, vCount;
    logic        hSyncIn, vSyncIn, blankBIn, frameDone;
    logic        rdEn, rdBank, wrBank, swapAck;
    logic [16:0] rdAddr;
    logic [7:0]  rdData;
    logic        hSync, vSync, blankB;
    logic [7:0]  red, green, blue;

    always #5 vgaClk = ~vgaClk;

    vga_pixel_fetch dut (
        .vgaClk   (vgaClk),
        .rstN     (rstN),
        .hCount   (hCount),
        .vCount   (vCount),
        .hSyncIn  (hSyncIn),
        .vSyncIn  (vSyncIn),
        .blankBIn (blankBIn),
        .frameDone(frameDone),
        .rdEn     (rdEn),
        .rdBank   (rdBank),
        .rdAddr   (rdAddr),
        .rdData   (rdData),
        .wrBank   (wrBank),
        .swapAck  (swapAck),
        .hSync    (hSync),
        .vSync    (vSync),
        .blankB   (blankB),
        .red      (red),
        .green    (green),
        .blue     (blue)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] px;
    } ent_t;

    ent_t        hist [3];     // hist[0] = sample taken at the latest edge
    logic        mPend, mBank, mAck, mEn;
    logic [16:0] mAddr;
    logic [7:0]  nextData;

    // Contents of the synthetic frame buffer; the two banks hold different data.
    function automatic logic [7:0] pix(input logic b, input logic [16:0] a);
        return 8'((a * 17'd13) ^ (a >> 7)) ^ (b ? 8'hC3 : 8'h3C);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, update the model from the inputs just sampled,
    // compare every output, then serve the memory read issued last cycle.
    task automatic step();
        ent_t e;
        logic act, sp;
        @(posedge vgaClk);
        #1;
        if (!rstN) begin
            mPend = 1'b0; mBank = 1'b0; mAck = 1'b0; mEn = 1'b0; mAddr = '0;
            e = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, px: 8'h00};
            hist[0] = e; hist[1] = e; hist[2] = e;
        end else begin
            act = blankBIn && (hCount < 640) && (vCount < 480);
            sp  = (hCount == 0) && (vCount == 480);
            mAck = mPend && sp;
            if (mPend && sp) begin
                mBank = !mBank;
                mPend = frameDone;
            end else if (frameDone) begin
                mPend = 1'b1;
            end
            mEn = act;
            if (act) mAddr = 17'((vCount / 2) * 320 + (hCount / 2));
            e.hs = hSyncIn;
            e.vs = vSyncIn;
            e.bl = blankBIn;
            e.px = act ? pix(mBank, mAddr) : 8'h00;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = e;
        end
        chk("rdEn",    rdEn,    mEn);
        chk("rdAddr",  rdAddr,  mAddr);
        chk("rdBank",  rdBank,  mBank);
        chk("wrBank",  wrBank,  !mBank);
        chk("swapAck", swapAck, mAck);
        chk("hSync",   hSync,   hist[2].hs);
        chk("vSync",   vSync,   hist[2].vs);
        chk("blankB",  blankB,  hist[2].bl);
        chk("red",     red,     hist[2].px);
        chk("green",   green,   hist[2].px);
        chk("blue",    blue,    hist[2].px);
        rdData   = nextData;
        nextData = rdEn ? pix(rdBank, rdAddr) : 8'($urandom);
    endtask

    task automatic cyc(input int hc, input int vc, input logic bl, input logic fd);
        hCount    = 10'(hc);
        vCount    = 10'(vc);
        blankBIn  = bl;
        frameDone = fd;
        hSyncIn   = 1'($urandom);
        vSyncIn   = 1'($urandom);
        step();
    endtask

    initial begin
        int hc, vc, r;
        logic bl;
        rdData = 8'h00; nextData = 8'h00;
        rstN = 1'b0;
        hCount = '0; vCount = '0; hSyncIn = 1'b1; vSyncIn = 1'b1;
        blankBIn = 1'b0; frameDone = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_rdEn", rdEn, 0);
        chk("rst_red", red, 0);
        chk("rst_hSync", hSync, 1);
        chk("rst_blankB", blankB, 0);
        rstN = 1'b1;

        // A single read, then the pixel it returns.
        cyc(5, 3, 1, 0);
        chk("addr322_en", rdEn, 1);
        chk("addr322", rdAddr, 322);
        cyc(700, 500, 0, 0);
        cyc(700, 500, 0, 0);
        chk("rgb322", red, pix(0, 322));

        // The last active pixel, then the first pixel past the right edge.
        cyc(639, 479, 1, 0);
        chk("addr_max", rdAddr, 76799);
        cyc(640, 479, 1, 0);
        chk("off_en", rdEn, 0);
        chk("off_hold", rdAddr, 76799);
        cyc(700, 500, 0, 0);
        chk("rgb_max", red, pix(0, 76799));
        cyc(700, 500, 0, 0);
        chk("rgb_off", red, 0);

        // Two frameDone pulses before the swap point give a single swap.
        cyc(0, 100, 1, 1);
        cyc(5, 100, 1, 1);
        for (int i = 0; i < 20; i++) cyc(i * 7, 100 + i, 1, 0);
        chk("preswap_bank", rdBank, 0);
        cyc(0, 480, 0, 0);
        chk("swap_ack", swapAck, 1);
        chk("swap_rd", rdBank, 1);
        chk("swap_wr", wrBank, 0);
        cyc(0, 481, 0, 0);
        chk("ack_pulse", swapAck, 0);
        cyc(0, 480, 0, 0);
        chk("single_swap", swapAck, 0);

        // A frameDone on the swap point while pending swaps and re-arms.
        cyc(0, 200, 1, 1);
        cyc(0, 480, 0, 1);
        chk("rearm_ack", swapAck, 1);
        chk("rearm_bank", rdBank, 0);
        cyc(10, 10, 1, 0);
        cyc(0, 480, 0, 0);
        chk("second_ack", swapAck, 1);
        chk("second_bank", rdBank, 1);

        // A frameDone on the swap point while idle arms without swapping.
        cyc(0, 480, 0, 1);
        chk("idle_sp_ack", swapAck, 0);
        cyc(0, 480, 0, 0);
        chk("idle_sp_next", swapAck, 1);
        chk("idle_sp_bank", rdBank, 0);
        cyc(0, 480, 0, 0);

        // One reset cycle while pending on bank 1 discards the pending swap.
        cyc(0, 480, 0, 1);
        cyc(0, 480, 0, 0);
        chk("b1_bank", rdBank, 1);
        cyc(3, 3, 1, 1);
        rstN = 1'b0;
        cyc(7, 7, 1, 0);
        chk("rstp_bank", rdBank, 0);
        chk("rstp_addr", rdAddr, 0);
        chk("rstp_vSync", vSync, 1);
        rstN = 1'b1;
        cyc(0, 480, 0, 0);
        chk("rstp_noack", swapAck, 0);
        chk("rstp_bank2", rdBank, 0);

        // Random raster positions, swap points, frameDone pulses and resets.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                hc = 0; vc = 480;
            end else if (r < 3) begin
                hc = int'($urandom_range(636, 643));
                vc = int'($urandom_range(476, 483));
            end else begin
                hc = int'($urandom_range(0, 799));
                vc = int'($urandom_range(0, 524));
            end
            if (hc < 640 && vc < 480) bl = ($urandom_range(0, 7) != 0);
            else                      bl = ($urandom_range(0, 3) == 0);
            rstN = ($urandom_range(0, 299) != 0);
            cyc(hc, vc, bl, $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
